// File: rtl/ae_exposure_ctrl.sv
// Closed-loop auto-exposure controller: compares per-frame average luma against a target
// and pushes a clamped proportional exposure update to the sensor as two byte writes.
//
// state  | meaning
// IDLE   | waiting for an enabled frame statistic
// EVAL   | one cycle: error, dead band, step and clamp
// WR_HI  | presenting exposure[15:8] to the register master
// WR_LO  | presenting exposure[7:0]; handshake commits the new exposure
// SETTLE | skipping frame statistics while the sensor settles
module ae_exposure_ctrl #(
    parameter logic [7:0]  TARGET_Y      = 8'd110,
    parameter logic [7:0]  HYST          = 8'd8,
    parameter int unsigned STEP_SHIFT    = 3,
    parameter logic [15:0] EXP_INIT      = 16'd400,
    parameter logic [15:0] EXP_MIN       = 16'd4,
    parameter logic [15:0] EXP_MAX       = 16'd1000,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter logic [15:0] REG_EXP_HI    = 16'h0202,
    parameter logic [15:0] REG_EXP_LO    = 16'h0203
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  avg_y,
    input  logic        stat_valid,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] exposure_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EVAL   = 3'd1,
        WR_HI  = 3'd2,
        WR_LO  = 3'd3,
        SETTLE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  avg_q, avg_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] exp_new_q, exp_new_d;
    logic        wr_valid_q, wr_valid_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  settle_q, settle_d;

    logic signed [8:0]  err;
    logic [8:0]         err_mag;
    logic [15:0]        step;
    logic [16:0]        sum;
    logic signed [16:0] diff;
    logic [15:0]        exp_calc;

    // Arithmetic is widened so neither the increase nor the decrease can wrap before clamping.
    always_comb begin
        err      = $signed({1'b0, avg_q}) - $signed({1'b0, TARGET_Y});
        err_mag  = err[8] ? 9'(-err) : 9'(err);
        step     = exp_q >> STEP_SHIFT;
        if (step == 16'd0) begin
            step = 16'd1;
        end
        sum      = {1'b0, exp_q} + {1'b0, step};
        diff     = $signed({1'b0, exp_q}) - $signed({1'b0, step});
        exp_calc = exp_q;
        if (err[8]) begin
            exp_calc = (sum > {1'b0, EXP_MAX}) ? EXP_MAX : sum[15:0];
        end else begin
            exp_calc = (diff < $signed({1'b0, EXP_MIN})) ? EXP_MIN : diff[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        avg_d      = avg_q;
        exp_d      = exp_q;
        exp_new_d  = exp_new_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        settle_d   = settle_q;
        case (state_q)
            IDLE: begin
                if (stat_valid && enable) begin
                    avg_d   = avg_y;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if ((err_mag <= {1'b0, HYST}) || (exp_calc == exp_q)) begin
                    state_d = IDLE;
                end else begin
                    exp_new_d  = exp_calc;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = REG_EXP_HI;
                    wr_data_d  = exp_calc[15:8];
                    state_d    = WR_HI;
                end
            end
            WR_HI: begin
                if (wr_ready) begin
                    wr_addr_d = REG_EXP_LO;
                    wr_data_d = exp_new_q[7:0];
                    state_d   = WR_LO;
                end
            end
            WR_LO: begin
                if (wr_ready) begin
                    exp_d      = exp_new_q;
                    wr_valid_d = 1'b0;
                    settle_d   = 8'(SETTLE_FRAMES);
                    state_d    = (SETTLE_FRAMES == 0) ? IDLE : SETTLE;
                end
            end
            SETTLE: begin
                if (stat_valid) begin
                    if (settle_q <= 8'd1) begin
                        settle_d = 8'd0;
                        state_d  = IDLE;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            avg_q      <= 8'd0;
            exp_q      <= EXP_INIT;
            exp_new_q  <= EXP_INIT;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 16'd0;
            wr_data_q  <= 8'd0;
            settle_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            avg_q      <= avg_d;
            exp_q      <= exp_d;
            exp_new_q  <= exp_new_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            settle_q   <= settle_d;
        end
    end

    assign wr_valid     = wr_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign exposure_out = exp_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ae_exposure_ctrl.sv
// Bench for ae_exposure_ctrl: a frame-level reference model predicts every output each cycle,
// directed cases pin the model with hand-computed values, then randomized frames follow.
module tb_ae_exposure_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  avg_y;
    logic        stat_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] exposure_out;
    logic        busy;

    ae_exposure_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .avg_y        (avg_y),
        .stat_valid   (stat_valid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .exposure_out (exposure_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, updated just after each clock edge.
    int          exp_m    = 400;
    int          settle_m = 0;
    bit          wv_m     = 1'b0;
    bit          busy_m   = 1'b0;
    logic [15:0] a_m      = 16'h0;
    logic [7:0]  d_m      = 8'h0;
    bit          chk_en   = 1'b0;

    // Stimulus knobs.
    int stall_hi = 0;
    int stall_lo = 0;
    bit inject   = 1'b0;
    bit toggle   = 1'b0;
    bit abort_lo = 1'b0;

    logic [23:0] hs_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("exposure_out", 32'(exposure_out), 32'(exp_m));
            check("wr_valid", 32'(wr_valid), 32'(wv_m));
            check("busy", 32'(busy), 32'(busy_m));
            if (wv_m) begin
                check("wr_addr", 32'(wr_addr), 32'(a_m));
                check("wr_data", 32'(wr_data), 32'(d_m));
            end
        end
        if (rst_n && wr_valid && wr_ready) hs_q.push_back({wr_addr, wr_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_m    = 400;
        settle_m = 0;
        wv_m     = 1'b0;
        busy_m   = 1'b0;
    endtask

    task automatic do_byte(input int stall);
        repeat (stall) begin
            wr_ready = 1'b0;
            if (inject && ($urandom_range(0, 1) == 1)) begin
                stat_valid = 1'b1;
                avg_y      = 8'($urandom_range(0, 255));
            end
            if (toggle && ($urandom_range(0, 2) == 0)) enable = ~enable;
            tick();
            stat_valid = 1'b0;
        end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
    endtask

    // One frame statistic pulse and everything the controller does in response.
    task automatic send_stat(input logic [7:0] av);
        int err, mag, step, nw;
        bit en;
        en         = enable;
        stat_valid = 1'b1;
        avg_y      = av;
        tick();
        stat_valid = 1'b0;
        if (settle_m > 0) begin
            settle_m--;
            busy_m = (settle_m != 0);
            return;
        end
        if (!en) return;
        busy_m = 1'b1;
        err  = int'(av) - 110;
        mag  = (err < 0) ? -err : err;
        step = exp_m / 8;
        if (step < 1) step = 1;
        if (err < 0) nw = (exp_m + step > 1000) ? 1000 : exp_m + step;
        else         nw = (exp_m - step < 4) ? 4 : exp_m - step;
        tick();
        if (mag <= 8 || nw == exp_m) begin
            busy_m = 1'b0;
            return;
        end
        wv_m = 1'b1;
        a_m  = 16'h0202;
        d_m  = 8'(nw / 256);
        do_byte(stall_hi);
        a_m = 16'h0203;
        d_m = 8'(nw % 256);
        if (abort_lo) begin
            tick();
            tick();
            rst_n = 1'b0;
            model_reset();
            #1;
            check("rst_wr_valid", 32'(wr_valid), 32'd0);
            check("rst_exposure", 32'(exposure_out), 32'd400);
            check("rst_busy", 32'(busy), 32'd0);
            tick();
            rst_n = 1'b1;
            return;
        end
        do_byte(stall_lo);
        wv_m     = 1'b0;
        exp_m    = nw;
        settle_m = 2;
        busy_m   = 1'b1;
    endtask

    task automatic expect_pair(input string name, input logic [23:0] hi, input logic [23:0] lo);
        check({name, "_count"}, 32'(hs_q.size()), 32'd2);
        if (hs_q.size() >= 2) begin
            check({name, "_hi"}, 32'(hs_q[$-1]), 32'(hi));
            check({name, "_lo"}, 32'(hs_q[$]), 32'(lo));
        end
        hs_q.delete();
    endtask

    task automatic settle_out();
        while (settle_m > 0) send_stat(8'd110);
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        avg_y      = 8'd0;
        stat_valid = 1'b0;
        wr_ready   = 1'b0;
        repeat (3) tick();
        check("reset_wr_valid", 32'(wr_valid), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_exposure", 32'(exposure_out), 32'd400);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        send_stat(8'd115);
        send_stat(8'd102);
        check("deadband_no_write", 32'(hs_q.size()), 32'd0);

        send_stat(8'd40);
        expect_pair("dark_400", 24'h020201, 24'h0203C2);
        check("dark_400_exposure", 32'(exposure_out), 32'd450);

        send_stat(8'd40);
        send_stat(8'd40);
        check("settle_no_write", 32'(hs_q.size()), 32'd0);
        send_stat(8'd40);
        expect_pair("after_settle", 24'h020201, 24'h0203FA);
        check("after_settle_exposure", 32'(exposure_out), 32'd506);
        settle_out();

        abort_lo = 1'b1;
        send_stat(8'd200);
        abort_lo = 1'b0;
        hs_q.delete();
        tick();

        stall_hi = 5;
        stall_lo = 5;
        inject   = 1'b1;
        send_stat(8'd200);
        expect_pair("bright_400", 24'h020201, 24'h02035E);
        check("bright_400_exposure", 32'(exposure_out), 32'd350);
        stall_hi = 0;
        stall_lo = 0;
        inject   = 1'b0;
        settle_out();

        for (int i = 0; i < 20 && exp_m < 1000; i++) begin
            send_stat(8'd20);
            settle_out();
            if (exp_m < 1000) hs_q.delete();
        end
        expect_pair("clamp_max", 24'h020203, 24'h0203E8);
        check("clamp_max_exposure", 32'(exposure_out), 32'd1000);
        send_stat(8'd20);
        check("at_clamp_no_write", 32'(hs_q.size()), 32'd0);

        enable = 1'b0;
        send_stat(8'd40);
        check("disabled_no_write", 32'(hs_q.size()), 32'd0);
        enable = 1'b1;

        for (int i = 0; i < 300; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            stall_hi = $urandom_range(0, 3);
            stall_lo = $urandom_range(0, 3);
            inject   = $urandom_range(0, 1);
            toggle   = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       send_stat(8'($urandom_range(0, 255)));
                1:       send_stat(8'($urandom_range(95, 125)));
                default: send_stat(8'($urandom_range(0, 30)));
            endcase
            if ($urandom_range(0, 3) == 0) tick();
        end
        hs_q.delete();
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
